regfile_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 32x32 register file, which has a single write port (Write_Reg/W_Addr/W_Data).
- Shares that port between NREQ writeback sources (e.g. ALU, load unit, mul/div) using round-robin arbitration and a valid/ready handshake.
- Drives the register-file write port from a registered output stage.
- Filters writes to r0 and counts committed writes.

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin writeback arbiter and registered write stage for
//               the single-write-port register file; filters r0 writes and
//               counts committed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               stall,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic [CW-1:0]      wr_count,
  output logic               conflict
);

  localparam int              c_PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_PW:0]   c_NREQ = (c_PW+1)'(NREQ);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(NREQ-1);

  logic [c_PW-1:0]   r_rr_ptr;
  logic [2*NREQ-1:0] w_rot;
  logic [c_PW-1:0]   w_off;
  logic [c_PW:0]     w_sum;
  logic [c_PW:0]     w_wrap;
  logic [c_PW-1:0]   w_gidx;
  logic [c_PW-1:0]   w_next;
  logic              w_grant;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_data;

  // Rotating a doubled copy puts the requester at rr_ptr in bit 0, so the
  // lowest set bit is the distance to the winner in round-robin order.
  assign w_rot = {req_valid, req_valid} >> r_rr_ptr;

  always_comb begin
    w_off = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (w_rot[j]) w_off = c_PW'(j);
    end
  end

  assign w_sum   = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_wrap  = (w_sum >= c_NREQ) ? (w_sum - c_NREQ) : w_sum;
  assign w_gidx  = w_wrap[c_PW-1:0];
  assign w_next  = (w_gidx == c_LAST) ? '0 : (w_gidx + c_PW'(1));
  assign w_grant = (|req_valid) & ~stall & ~rst;

  always_comb begin
    req_ready  = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == c_PW'(i)) begin
        req_ready[i] = w_grant;
        w_sel_addr   = req_addr[i*AW +: AW];
        w_sel_data   = req_data[i*DW +: DW];
      end
    end
  end

  assign conflict = (req_valid & (req_valid - NREQ'(1))) != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_count <= '0;
    end else begin
      if (wr_en && (wr_count != {CW{1'b1}})) begin
        wr_count <= wr_count + CW'(1);
      end
      // Writes to r0 are consumed but never reach the register file.
      if (w_grant) begin
        r_rr_ptr <= w_next;
        wr_en    <= |w_sel_addr;
        wr_addr  <= w_sel_addr;
        wr_data  <= w_sel_data;
      end else begin
        wr_en    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench: directed vector table, hand sequences
//               and random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               stall;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [CW-1:0]      wr_count;
  logic               conflict;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_count  (wr_count),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        stl;
    logic [2:0]  rdy;
    logic        cfl;
    logic        en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  cnt;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input logic s, input logic [2:0] r, input logic c, input logic e,
                              input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] n);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.stl = s; t.rdy = r; t.cfl = c;
    t.en = e; t.waddr = wa; t.wdata = wd; t.cnt = n;
    return t;
  endfunction

  // Behavioural model: first valid index searching upward from ptr.
  function automatic int arb(input logic [2:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  vec_t tbl[16];
  localparam logic [31:0] DA = 32'hAAAA0001, DB = 32'hBBBB0002, DC = 32'hCCCC0003;

  initial begin
    logic [2:0]  prev;
    logic [2:0]  pend;
    logic [4:0]  pa[NREQ];
    logic [31:0] pd[NREQ];
    int          m_ptr, m_cnt, g, pc;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [2:0]  er;

    tbl[0]  = mk(3'b001, {10'd0, 5'd5}, {64'd0, 32'hDEADBEEF}, 0, 3'b001, 0, 0, 5'd0, 32'h0, 4'd0);
    tbl[1]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b000, 0, 1, 5'd5, 32'hDEADBEEF, 4'd0);
    tbl[2]  = mk(3'b100, {5'd7, 10'd0}, {32'h77, 64'd0}, 0, 3'b100, 0, 0, 5'd5, 32'hDEADBEEF, 4'd1);
    tbl[3]  = mk(3'b111, {5'd3, 5'd2, 5'd1}, {DC, DB, DA}, 0, 3'b001, 1, 1, 5'd7, 32'h77, 4'd1);
    tbl[4]  = mk(3'b110, {5'd3, 5'd2, 5'd1}, {DC, DB, DA}, 0, 3'b010, 1, 1, 5'd1, DA, 4'd2);
    tbl[5]  = mk(3'b100, {5'd3, 5'd2, 5'd1}, {DC, DB, DA}, 0, 3'b100, 0, 1, 5'd2, DB, 4'd3);
    tbl[6]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b000, 0, 1, 5'd3, DC, 4'd4);
    tbl[7]  = mk(3'b010, 15'd0, {32'd0, 32'h1234, 32'd0}, 0, 3'b010, 0, 0, 5'd3, DC, 4'd5);
    tbl[8]  = mk(3'b000, 15'd0, 96'd0, 0, 3'b000, 0, 0, 5'd0, 32'h1234, 4'd5);
    tbl[9]  = mk(3'b100, 15'd0, 96'd0, 0, 3'b100, 0, 0, 5'd0, 32'h1234, 4'd5);
    tbl[10] = mk(3'b110, {5'd10, 5'd9, 5'd0}, {32'hAA, 32'h99, 32'd0}, 1, 3'b000, 1, 0, 5'd0, 32'h0, 4'd5);
    tbl[11] = mk(3'b110, {5'd10, 5'd9, 5'd0}, {32'hAA, 32'h99, 32'd0}, 1, 3'b000, 1, 0, 5'd0, 32'h0, 4'd5);
    tbl[12] = mk(3'b110, {5'd10, 5'd9, 5'd0}, {32'hAA, 32'h99, 32'd0}, 1, 3'b000, 1, 0, 5'd0, 32'h0, 4'd5);
    tbl[13] = mk(3'b110, {5'd10, 5'd9, 5'd0}, {32'hAA, 32'h99, 32'd0}, 0, 3'b010, 1, 0, 5'd0, 32'h0, 4'd5);
    tbl[14] = mk(3'b100, {5'd10, 5'd9, 5'd0}, {32'hAA, 32'h99, 32'd0}, 0, 3'b100, 0, 1, 5'd9, 32'h99, 4'd5);
    tbl[15] = mk(3'b000, 15'd0, 96'd0, 0, 3'b000, 0, 1, 5'd10, 32'hAA, 4'd6);

    // Reset state; a request presented during reset must not be accepted
    rst = 1'b1; stall = 1'b0; req_valid = 3'b001; req_addr = '0; req_data = '0;
    #7;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_addr",  32'(wr_addr), 32'h0);
    chk("rst_data",  wr_data, 32'h0);
    chk("rst_count", 32'(wr_count), 32'h0);
    req_valid = 3'b000;
    #5 rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      req_valid = tbl[k].valid; req_addr = tbl[k].addr; req_data = tbl[k].data; stall = tbl[k].stl;
      @(negedge clk);
      chk($sformatf("v%0d_ready", k),    32'(req_ready), 32'(tbl[k].rdy));
      chk($sformatf("v%0d_conflict", k), 32'(conflict),  32'(tbl[k].cfl));
      chk($sformatf("v%0d_wr_en", k),    32'(wr_en),     32'(tbl[k].en));
      chk($sformatf("v%0d_wr_addr", k),  32'(wr_addr),   32'(tbl[k].waddr));
      chk($sformatf("v%0d_wr_data", k),  wr_data,        tbl[k].wdata);
      chk($sformatf("v%0d_count", k),    32'(wr_count),  32'(tbl[k].cnt));
      @(posedge clk); #1;
    end

    // Reset in the cycle after a grant: pending write dropped, pointer cleared
    req_valid = 3'b001; req_addr = {10'd0, 5'd4}; req_data = {64'd0, 32'h44};
    @(posedge clk); #1;
    chk("mid_pre_en", 32'(wr_en), 32'h1);
    req_valid = 3'b011; req_addr = {5'd0, 5'd6, 5'd8}; req_data = {32'd0, 32'h66, 32'h88};
    #3 rst = 1'b1;
    #1;
    chk("mid_wr_en",  32'(wr_en), 32'h0);
    chk("mid_count",  32'(wr_count), 32'h0);
    chk("mid_ready",  32'(req_ready), 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b001);
    chk("post_rst_wr_en", 32'(wr_en), 32'h0);
    @(posedge clk); #1;
    req_valid = 3'b010;
    @(negedge clk);
    chk("post_rst_ready1", 32'(req_ready), 32'b010);
    chk("post_rst_write0", 32'(wr_addr), 32'd8);
    @(posedge clk); #1;

    // Saturation: sustained writes through requester 0
    for (int i = 0; i < 20; i++) begin
      req_valid = 3'b001; req_addr = {10'd0, 5'd1}; req_data = {64'd0, 32'(i)};
      @(negedge clk);
      chk("sat_ready", 32'(req_ready), 32'b001);
      @(posedge clk); #1;
    end
    req_valid = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_count", 32'(wr_count), 32'd15);

    // Fairness: requesters 0 and 2 always valid must alternate
    prev = 3'b001;
    for (int i = 0; i < 6; i++) begin
      req_valid = 3'b101; req_addr = {5'd2, 5'd0, 5'd3}; req_data = {32'(100 + i), 32'd0, 32'(200 + i)};
      @(negedge clk);
      chk("fair_onehot", 32'((req_ready == 3'b001) || (req_ready == 3'b100)), 32'h1);
      chk("fair_alt", 32'(req_ready), 32'(~prev & 3'b101));
      prev = req_ready;
      @(posedge clk); #1;
    end

    // Random traffic against the model
    req_valid = '0; rst = 1'b1; #2 rst = 1'b0;
    m_ptr = 0; m_cnt = 0; m_en = 1'b0; m_addr = '0; m_data = '0; pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
          pd[i] = $urandom;
        end
        req_addr[i*AW +: AW] = pa[i];
        req_data[i*DW +: DW] = pd[i];
      end
      req_valid = pend;
      stall = ($urandom_range(0, 9) == 0);
      g  = stall ? -1 : arb(pend, m_ptr);
      er = (g >= 0) ? 3'(1 << g) : 3'b000;
      pc = 0;
      for (int i = 0; i < NREQ; i++) pc += int'(pend[i]);
      @(negedge clk);
      chk("rnd_ready",    32'(req_ready), 32'(er));
      chk("rnd_conflict", 32'(conflict),  32'(pc > 1));
      chk("rnd_wr_en",    32'(wr_en),     32'(m_en));
      chk("rnd_wr_addr",  32'(wr_addr),   32'(m_addr));
      chk("rnd_wr_data",  wr_data,        m_data);
      chk("rnd_count",    32'(wr_count),  32'(m_cnt));
      @(posedge clk);
      if (m_en && m_cnt < 15) m_cnt++;
      if (g >= 0) begin
        m_en = (pa[g] != 0); m_addr = pa[g]; m_data = pd[g];
        m_ptr = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
